// File: rtl/subsystem_axil_pkg.sv
// Shared types and helpers for the subsystem AXI4-Lite register slice.
package subsystem_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) merged[8*k +: 8] = data[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/subsystem_axil_regfile.sv
// Software register array: strobed writes with per-register pulse and a
// combinational read mux; out-of-range indices report as misses.
module subsystem_axil_regfile
  import subsystem_axil_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_index,
  input  logic [31:0]             wr_data,
  input  logic [3:0]              wr_strb,
  output logic                    wr_hit,
  input  logic [IDX_W-1:0]        rd_index,
  output logic [31:0]             rd_data,
  output logic                    rd_hit,
  output logic [32*NUM_REGS-1:0]  regs_out,
  output logic [NUM_REGS-1:0]     reg_wr_pulse
);

  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && wr_index == IDX_W'(i)) begin
          regs[i]         <= strb_merge(regs[i], wr_data, wr_strb);
          reg_wr_pulse[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_hit  = 1'b0;
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_index == IDX_W'(i)) wr_hit = 1'b1;
      if (rd_index == IDX_W'(i)) begin
        rd_hit  = 1'b1;
        rd_data = regs[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[32*g +: 32] = regs[g];
  end

endmodule

// File: rtl/subsystem_axil_regs.sv
// AXI4-Lite responder for the subsystem S00_AXI port: independent write and
// read handshake FSMs in front of the software register file.
module subsystem_axil_regs
  import subsystem_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 4
) (
  input  logic                     s00_axi_aclk,
  input  logic                     s00_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]    s00_axi_awaddr,
  input  logic [2:0]               s00_axi_awprot,
  input  logic                     s00_axi_awvalid,
  output logic                     s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]    s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]  s00_axi_wstrb,
  input  logic                     s00_axi_wvalid,
  output logic                     s00_axi_wready,
  output logic [1:0]               s00_axi_bresp,
  output logic                     s00_axi_bvalid,
  input  logic                     s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]    s00_axi_araddr,
  input  logic [2:0]               s00_axi_arprot,
  input  logic                     s00_axi_arvalid,
  output logic                     s00_axi_arready,
  output logic [DATA_WIDTH-1:0]    s00_axi_rdata,
  output logic [1:0]               s00_axi_rresp,
  output logic                     s00_axi_rvalid,
  input  logic                     s00_axi_rready,
  output logic [32*NUM_REGS-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("subsystem_axil_regs: DATA_WIDTH must be 32");
  end
  if (NUM_REGS < 1 || NUM_REGS > 16 || NUM_REGS * 4 > (1 << ADDR_WIDTH)) begin : g_bad_num_regs
    $error("subsystem_axil_regs: NUM_REGS out of range for ADDR_WIDTH");
  end

  wr_state_t        wr_state, wr_state_next;
  rd_state_t        rd_state, rd_state_next;
  logic             live;
  logic             aw_held, w_held;
  logic [IDX_W-1:0] aw_index;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic             wr_hit, rd_hit;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
  assign w_hs   = s00_axi_wvalid  && s00_axi_wready;
  assign b_hs   = s00_axi_bvalid  && s00_axi_bready;
  assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
  assign r_hs   = s00_axi_rvalid  && s00_axi_rready;
  assign commit = (wr_state == WR_IDLE) && aw_held && w_held;

  // live keeps every ready low until the first edge after reset release.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      live     <= 1'b0;
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      live     <= 1'b1;
      wr_state <= wr_state_next;
      rd_state <= rd_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state;
    rd_state_next = rd_state;
    case (wr_state)
      WR_IDLE: if (aw_held && w_held) wr_state_next = WR_RESP;
      WR_RESP: if (s00_axi_bready)    wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_state_next = RD_DATA;
      RD_DATA: if (r_hs)  rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    s00_axi_awready = live && (wr_state == WR_IDLE) && !aw_held;
    s00_axi_wready  = live && (wr_state == WR_IDLE) && !w_held;
    s00_axi_bvalid  = (wr_state == WR_RESP);
    s00_axi_arready = live && (rd_state == RD_IDLE);
    s00_axi_rvalid  = (rd_state == RD_DATA);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_index      <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      s00_axi_bresp <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_index <= s00_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
      if (commit) s00_axi_bresp <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Read data is sampled on the AR edge, so a same-edge commit is not seen.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_rdata <= '0;
      s00_axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s00_axi_rdata <= rd_data;
      s00_axi_rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  subsystem_axil_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk          (s00_axi_aclk),
    .rst_n        (s00_axi_aresetn),
    .wr_en        (commit),
    .wr_index     (aw_index),
    .wr_data      (w_data),
    .wr_strb      (w_strb),
    .wr_hit       (wr_hit),
    .rd_index     (s00_axi_araddr[ADDR_WIDTH-1:2]),
    .rd_data      (rd_data),
    .rd_hit       (rd_hit),
    .regs_out     (regs_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

endmodule

// File: tb/tb_subsystem_axil_regs.sv
// Directed self-checking bench for subsystem_axil_regs: register access,
// handshake ordering, strobes, error responses, collisions and async reset.
module tb_subsystem_axil_regs;
  import subsystem_axil_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [5:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] regs_out;
  logic [3:0]   reg_wr_pulse;

  int           error_count = 0;
  int           check_count = 0;
  int           pulse_cycles = 0;
  logic [3:0]   pulse_last = '0;
  logic [31:0]  model [4];

  subsystem_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(4)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .regs_out        (regs_out),
    .reg_wr_pulse    (reg_wr_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr_pulse != 4'b0000) begin
      pulse_cycles <= pulse_cycles + 1;
      pulse_last   <= reg_wr_pulse;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyWrite(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
    int   n;
    logic hs_aw, hs_w, got_b;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      n++;
      if (hs_aw) awvalid = 1'b0;
      if (hs_w)  wvalid = 1'b0;
    end
    while (!bvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    got_b = bvalid;
    resp  = bresp;
    @(negedge clk);
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("wr_complete", 128'(got_b), 128'(1'b1));
  endtask

  task automatic applyRead(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int   n;
    logic ar_done, got_r;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    ar_done = 1'b0;
    while (!ar_done && n < 20) begin
      ar_done = arready;
      @(negedge clk);
      n++;
    end
    arvalid = 1'b0;
    while (!rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    got_r = rvalid;
    data  = rdata;
    resp  = rresp;
    @(negedge clk);
    rready = 1'b0;
    checkOutput("rd_complete", 128'(got_r), 128'(1'b1));
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic [5:0]  addrs [4];
    logic [31:0] vals  [4];
    int          pulse_base;

    addrs = '{6'h00, 6'h04, 6'h08, 6'h0C};
    vals  = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset values while held in reset.
    @(negedge clk);
    checkOutput("rst_awready", 128'(awready), 128'(1'b0));
    checkOutput("rst_wready",  128'(wready),  128'(1'b0));
    checkOutput("rst_arready", 128'(arready), 128'(1'b0));
    checkOutput("rst_bvalid",  128'(bvalid),  128'(1'b0));
    checkOutput("rst_rvalid",  128'(rvalid),  128'(1'b0));
    checkOutput("rst_regs",    regs_out,      128'(0));
    checkOutput("rst_pulse",   128'(reg_wr_pulse), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", 128'({awready, wready, arready}), 128'(3'b111));

    // Fill all four registers and read each back.
    for (int i = 0; i < 4; i++) begin
      applyWrite(addrs[i], vals[i], 4'hF, resp);
      model[i] = vals[i];
      checkOutput("fill_bresp", 128'(resp), 128'(RESP_OKAY));
      applyRead(addrs[i], data, resp);
      checkOutput("fill_rresp", 128'(resp), 128'(RESP_OKAY));
      checkOutput("fill_rdata", 128'(data), 128'(vals[i]));
    end
    checkOutput("reg3_out", 128'(regs_out[127:96]), 128'(32'hBEEF0011));

    // W three cycles ahead of AW, B held off for five cycles.
    pulse_base = pulse_cycles;
    @(negedge clk);
    wdata = 32'h0000CAFE; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    checkOutput("order_wready_open", 128'(wready), 128'(1'b1));
    @(negedge clk);
    wvalid = 1'b0;
    checkOutput("order_wready_held", 128'(wready), 128'(1'b0));
    @(negedge clk);
    checkOutput("order_wready_held2", 128'(wready), 128'(1'b0));
    @(negedge clk);
    awaddr = 6'h00; awvalid = 1'b1;
    checkOutput("order_awready_open", 128'(awready), 128'(1'b1));
    @(negedge clk);
    awvalid = 1'b0;
    wdata = 32'hFFFFFFFF; wvalid = 1'b1;
    checkOutput("order_bvalid_early", 128'(bvalid), 128'(1'b0));
    checkOutput("order_awready_held", 128'(awready), 128'(1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("order_bvalid_stall", 128'(bvalid), 128'(1'b1));
      checkOutput("order_bresp_stall", 128'(bresp), 128'(RESP_OKAY));
      checkOutput("order_no_second_w", 128'(wready), 128'(1'b0));
    end
    wvalid = 1'b0;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    model[0] = 32'h0000CAFE;
    checkOutput("order_bvalid_done", 128'(bvalid), 128'(1'b0));
    checkOutput("order_awready_back", 128'(awready), 128'(1'b1));
    checkOutput("order_regs", regs_out, model_flat());
    checkOutput("order_pulses", 128'(pulse_cycles - pulse_base), 128'(1));

    // Partial-strobe write into register 1.
    pulse_base = pulse_cycles;
    applyWrite(6'h04, 32'h11223344, 4'b0101, resp);
    model[1] = 32'hAB220044;
    checkOutput("strb_bresp", 128'(resp), 128'(RESP_OKAY));
    checkOutput("strb_pulse_cycles", 128'(pulse_cycles - pulse_base), 128'(1));
    checkOutput("strb_pulse_value", 128'(pulse_last), 128'(4'b0010));
    checkOutput("strb_reg1", 128'(regs_out[63:32]), 128'(32'hAB220044));
    applyRead(6'h04, data, resp);
    checkOutput("strb_rdata", 128'(data), 128'(32'hAB220044));

    // Unmapped write and read.
    pulse_base = pulse_cycles;
    applyWrite(6'h20, 32'hFFFFFFFF, 4'hF, resp);
    checkOutput("unmap_bresp", 128'(resp), 128'(RESP_SLVERR));
    checkOutput("unmap_regs", regs_out, model_flat());
    checkOutput("unmap_no_pulse", 128'(pulse_cycles - pulse_base), 128'(0));
    applyRead(6'h3C, data, resp);
    checkOutput("unmap_rdata", 128'(data), 128'(0));
    checkOutput("unmap_rresp", 128'(resp), 128'(RESP_SLVERR));

    // Read of reg 2 sampled on the same edge its write commits, R stalled.
    @(negedge clk);
    awaddr = 6'h08; awvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    checkOutput("coll_aw_w_ready", 128'({awready, wready}), 128'(2'b11));
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h08; arvalid = 1'b1; rready = 1'b0;
    checkOutput("coll_arready", 128'(arready), 128'(1'b1));
    @(negedge clk);
    arvalid = 1'b0;
    model[2] = 32'h5;
    checkOutput("coll_bvalid", 128'(bvalid), 128'(1'b1));
    checkOutput("coll_reg2", 128'(regs_out[95:64]), 128'(32'h5));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("coll_rvalid", 128'(rvalid), 128'(1'b1));
      checkOutput("coll_rdata_old", 128'(rdata), 128'(32'hDEAD0011));
      checkOutput("coll_rresp", 128'(rresp), 128'(RESP_OKAY));
      checkOutput("coll_arready_low", 128'(arready), 128'(1'b0));
    end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    checkOutput("coll_done", 128'({rvalid, bvalid, arready}), 128'(3'b001));
    applyRead(6'h08, data, resp);
    checkOutput("coll_new_value", 128'(data), 128'(32'h5));

    // Reset asserted with AW held and W still pending.
    @(negedge clk);
    awaddr = 6'h0C; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checkOutput("mid_aw_held", 128'(awready), 128'(1'b0));
    #2;
    rst_n = 1'b0;
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    #1;
    checkOutput("mid_rst_readies", 128'({awready, wready, arready}), 128'(3'b000));
    checkOutput("mid_rst_valids", 128'({bvalid, rvalid}), 128'(2'b00));
    checkOutput("mid_rst_resp_data", 128'({bresp, rresp, rdata}), 128'(0));
    checkOutput("mid_rst_regs", regs_out, 128'(0));
    checkOutput("mid_rst_pulse", 128'(reg_wr_pulse), 128'(0));
    @(negedge clk);
    wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_no_b", 128'(bvalid), 128'(1'b0));
    end
    checkOutput("post_rst_awready", 128'(awready), 128'(1'b1));
    checkOutput("post_rst_regs", regs_out, 128'(0));

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/subsystem_axil_regs.md
Name: subsystem_axil_regs

Overview:
AXI4-Lite responder that terminates the S00_AXI port of the subsystem IP. It is the slave end that a master BFM writes to and reads back from. It holds NUM_REGS 32-bit software registers with byte-strobe writes, OKAY/SLVERR responses and independent write and read paths. The register contents are exported as a flat bus to the array-processor datapath, with a per-register write pulse.

Parameters:
DATA_WIDTH, 32, AXI data width; fixed at 32, any other value is an elaboration error.
ADDR_WIDTH, 6, AXI address width; byte addressed.
NUM_REGS, 4, number of implemented registers at offsets 0x0, 0x4, ... (NUM_REGS-1)*4; 1..16, and NUM_REGS*4 must be <= 2^ADDR_WIDTH.

Ports:
s00_axi_aclk  in  1  single clock; everything is on its rising edge.
s00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
s00_axi_awaddr  in  ADDR_WIDTH  write address.
s00_axi_awprot  in  3  ignored.
s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake.
s00_axi_wdata  in  32  write data.
s00_axi_wstrb  in  4  byte strobes.
s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake.
s00_axi_bresp  out  2  write response.
s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake.
s00_axi_araddr  in  ADDR_WIDTH  read address.
s00_axi_arprot  in  3  ignored.
s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake.
s00_axi_rdata  out  32  read data.
s00_axi_rresp  out  2  read response.
s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake.
regs_out  out  32*NUM_REGS  register contents; reg i occupies bits [32i+31:32i].
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle a register is updated.

Behaviour:
- Reset (async, aresetn=0):
  - all registers 0.
  - awready, wready, arready = 0.
  - bvalid, rvalid = 0.
  - bresp, rresp, rdata = 0.
  - reg_wr_pulse = 0.
  - Reset mid-transaction abandons the transaction; no partial writes.
  - Ready outputs rise on the first clock edge after deassertion.
- Address decode:
  - index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
  - Mapped if index < NUM_REGS, otherwise unmapped.
- Write path state machine, WR_IDLE -> WR_RESP -> WR_IDLE:
  - AW and W are captured independently into holding regs.
  - awready = 1 while in WR_IDLE and AW not yet held; wready likewise for W.
  - AW and W may arrive in either order or in the same cycle; a held beat keeps its ready low until the other beat arrives.
  - The cycle after both are held: commit the write, pulse reg_wr_pulse[index], set bvalid=1, enter WR_RESP.
  - Mapped commit: byte k updated iff wstrb[k]; bresp=OKAY (2'b00).
  - Unmapped commit: no register change, no pulse, bresp=SLVERR (2'b10).
  - bvalid holds, with bresp stable, until bready; then clear the holding regs and return to WR_IDLE.
  - Write latency: 1 cycle from the later of the AW/W handshakes to bvalid.
  - At most one write outstanding.
- Read path state machine, RD_IDLE -> RD_DATA -> RD_IDLE:
  - arready = 1 in RD_IDLE.
  - On AR handshake, register rdata/rresp and set rvalid on the next cycle (latency 1).
  - Mapped read: rdata = register value, rresp = OKAY.
  - Unmapped read: rdata = 0, rresp = SLVERR.
  - rvalid, rdata and rresp hold until rready; then return to RD_IDLE.
  - arready = 0 while in RD_DATA; no read pipelining.
- Simultaneous events:
  - A read and a write commit to the same register on the same edge: the read returns the pre-write value.
  - The read and write paths never stall each other.
- wstrb = 0 on a mapped address: no data change, but reg_wr_pulse still fires and bresp = OKAY.
- regs_out is driven directly from the registers; it updates the cycle after commit.

Decomposition:
- Package subsystem_axil_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - The write and read state enums.
  - The function strb_merge(old, data, strb).
- One sub-module, subsystem_axil_regfile: the register array, strobe merge, write pulses and combinational read mux. The top keeps the two handshake FSMs.

Test Plan:
- Reset is released, then write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, each followed by a read-back. Required: every bresp/rresp = OKAY, rdata matches, regs_out[127:96] = 0xBEEF0011.
- Write order and back-pressure: W presented 3 cycles before AW, with bready held low for 5 cycles. Required: wready drops after the W handshake, no second write is accepted, and bvalid is asserted 1 cycle after the AW handshake and is held until bready.
- Strobe write: reg 1 = 0xABCD0001, then write 0x11223344 with wstrb = 4'b0101. Required: reg 1 = 0xAB220044 and reg_wr_pulse = 4'b0010 for exactly one cycle.
- Unmapped write to 0x20 with data 0xFFFFFFFF. Required: bresp = SLVERR and all registers unchanged. Unmapped read from 0x3C. Required: rdata = 0, rresp = SLVERR.
- Read stall and collision: AR to 0x8 with rready low for 4 cycles, and on the AR cycle a write of 0x5 to 0x8 commits. Required: rdata = the old 0xDEAD0011, stable while stalled, and arready = 0 until the R handshake.
- Reset mid-write: assert aresetn=0 while AW is held and W is pending. Required: all outputs return to the reset values immediately (async), registers = 0, and no bvalid is issued after reset release.
